// File: rtl/pipe_pkg.sv
// Shared definitions for the RV32I elastic stage registers: stage states, control-bundle
// field layout, the NOP control word and default payload widths per pipeline boundary.
package pipe_pkg;

   // Encoded as {main_valid, skid_valid}; the value 2'b01 is never entered.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b10,
      ST_FULL  = 2'b11
   } stage_state_e;

   localparam int CTRL_W_DEF = 8;

   // Control bundle layout, LSB offsets and widths.
   localparam int ALU_OP_LSB = 0;
   localparam int ALU_OP_W   = 2;
   localparam int SRC1_LSB   = 2;
   localparam int SRC1_W     = 1;
   localparam int SRC2_LSB   = 3;
   localparam int SRC2_W     = 1;
   localparam int MEM_RD_LSB = 4;
   localparam int MEM_RD_W   = 1;
   localparam int MEM_WR_LSB = 5;
   localparam int MEM_WR_W   = 1;
   localparam int REG_WR_LSB = 6;
   localparam int REG_WR_W   = 1;
   localparam int WB_SEL_LSB = 7;
   localparam int WB_SEL_W   = 1;

   localparam logic [CTRL_W_DEF-1:0] CTRL_NOP = '0;

   localparam int DATA_W_IF_ID  = 64;
   localparam int DATA_W_ID_EX  = 160;
   localparam int DATA_W_EX_MEM = 104;
   localparam int DATA_W_MEM_WB = 72;

   // True when a control word would modify architectural state downstream.
   function automatic logic ctrl_has_side_effect(input logic [CTRL_W_DEF-1:0] ctrl);
      return ctrl[MEM_WR_LSB] | ctrl[REG_WR_LSB];
   endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with asynchronous active-high clear; holds at all-ones.
module pipe_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with a two-entry skid buffer, flush-to-bubble and masked control.
// Optional perf counters (bubble/stall) are built when PIPE_STAGE_PERF_EN is defined.
//
// Handshake: a beat transfers on a rising edge where valid and ready are both high; valid
// never depends on ready, and in_ready comes straight from registered state.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int                DATA_W   = DATA_W_ID_EX,
   parameter int                CTRL_W   = CTRL_W_DEF,
   parameter logic [CTRL_W-1:0] CTRL_RST = CTRL_W'(CTRL_NOP),
   parameter int                CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  bubble_cnt,
   output logic [CNT_W-1:0]  stall_cnt,
   output stage_state_e      state
);

   stage_state_e      state_nxt;
   logic              in_fire;
   logic              out_fire;
   logic              load_main;
   logic              load_skid;
   logic              move_skid;
   logic [CTRL_W-1:0] main_ctrl;
   logic [CTRL_W-1:0] skid_ctrl;
   logic [DATA_W-1:0] main_data;
   logic [DATA_W-1:0] skid_data;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      load_main = 1'b0;
      load_skid = 1'b0;
      move_skid = 1'b0;
      case (state)
         ST_EMPTY: begin
            if (in_fire) begin
               state_nxt = ST_ONE;
               load_main = 1'b1;
            end
         end
         ST_ONE: begin
            if (in_fire && out_fire) begin
               load_main = 1'b1;
            end else if (in_fire) begin
               state_nxt = ST_FULL;
               load_skid = 1'b1;
            end else if (out_fire) begin
               state_nxt = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (out_fire) begin
               state_nxt = ST_ONE;
               move_skid = 1'b1;
            end
         end
         default: state_nxt = ST_EMPTY;
      endcase
      // A flush drops everything, including a beat that fires this same cycle.
      if (flush) begin
         state_nxt = ST_EMPTY;
         load_main = 1'b0;
         load_skid = 1'b0;
         move_skid = 1'b0;
      end
   end

   always_comb begin
      in_ready  = (state != ST_FULL);
      out_valid = (state != ST_EMPTY);
      out_ctrl  = out_valid ? main_ctrl : CTRL_RST;
      out_data  = main_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_ctrl <= CTRL_RST;
         skid_ctrl <= CTRL_RST;
         main_data <= '0;
         skid_data <= '0;
      end else if (flush) begin
         main_ctrl <= CTRL_RST;
         skid_ctrl <= CTRL_RST;
      end else begin
         if (load_main) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
         end else if (move_skid) begin
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
         end
         if (load_skid) begin
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
         end
      end
   end

`ifdef PIPE_STAGE_PERF_EN
   pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (~out_valid),
      .count (bubble_cnt)
   );

   pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (out_valid & ~out_ready),
      .count (stall_cnt)
   );
`else
   assign bubble_cnt = '0;
   assign stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: reset, streaming, skid fill/drain, flush and perf counters.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pipe_stage_reg;
   import pipe_pkg::*;

   localparam int DW = 32;
   localparam int CW = 8;
   localparam int NW = 4;

   logic          clk;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [CW-1:0] in_ctrl;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] out_ctrl;
   logic [DW-1:0] out_data;
   logic [NW-1:0] bubble_cnt;
   logic [NW-1:0] stall_cnt;
   stage_state_e  state;

   int n_tests = 0;
   int n_fail  = 0;

   pipe_stage_reg #(
      .DATA_W   (DW),
      .CTRL_W   (CW),
      .CTRL_RST (8'h00),
      .CNT_W    (NW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_ctrl    (in_ctrl),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_ctrl   (out_ctrl),
      .out_data   (out_data),
      .bubble_cnt (bubble_cnt),
      .stall_cnt  (stall_cnt),
      .state      (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
      #12;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %0b want 1", in_ready); end
      n_tests++; if (out_ctrl !== 8'h00) begin n_fail++; $display("FAIL rst_out_ctrl got %h want 00", out_ctrl); end
      n_tests++; if (bubble_cnt !== 4'h0 || stall_cnt !== 4'h0) begin n_fail++; $display("FAIL rst_counters got %h/%h want 0/0", bubble_cnt, stall_cnt); end
      n_tests++; if (state !== ST_EMPTY) begin n_fail++; $display("FAIL rst_state got %b want 00", state); end
      // Load one beat, then hit it with an asynchronous reset between edges.
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b1; in_ctrl = 8'h5A; in_data = 32'h0000_1234;
      @(negedge clk);
      in_valid = 1'b0;
      n_tests++; if (out_valid !== 1'b1 || out_ctrl !== 8'h5A) begin n_fail++; $display("FAIL pre_rst_beat got v=%0b c=%h want v=1 c=5a", out_valid, out_ctrl); end
      #1 rst = 1'b1;
      #1;
      n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_ctrl !== 8'h00) begin
         n_fail++; $display("FAIL async_rst got v=%0b r=%0b c=%h want v=0 r=1 c=00", out_valid, in_ready, out_ctrl);
      end
      #1 rst = 1'b0;
      @(negedge clk);
      n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst got v=%0b r=%0b want v=0 r=1", out_valid, in_ready); end
   endtask

   task automatic test_stream();
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1; in_ctrl = 8'(i); in_data = 32'(i) | 32'hA500_0000;
         @(negedge clk);
         n_tests++;
         if (out_valid !== 1'b1 || out_ctrl !== 8'(i) || out_data !== (32'(i) | 32'hA500_0000) || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_%0d got v=%0b c=%h d=%h r=%0b want v=1 c=%h d=%h r=1",
                     i, out_valid, out_ctrl, out_data, in_ready, 8'(i), 32'(i) | 32'hA500_0000);
         end
      end
      in_valid = 1'b0;
      @(negedge clk);
      n_tests++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin n_fail++; $display("FAIL stream_end got v=%0b c=%h want v=0 c=00", out_valid, out_ctrl); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      in_valid = 1'b1; in_ctrl = 8'hA1; in_data = 32'hAAAA_AAAA;
      @(negedge clk);
      n_tests++; if (state !== ST_ONE || in_ready !== 1'b1) begin n_fail++; $display("FAIL bb_one got s=%b r=%0b want s=10 r=1", state, in_ready); end
      in_ctrl = 8'hB2; in_data = 32'hBBBB_BBBB;
      @(negedge clk);
      n_tests++; if (state !== ST_FULL || in_ready !== 1'b0) begin n_fail++; $display("FAIL bb_full got s=%b r=%0b want s=11 r=0", state, in_ready); end
      // A beat offered while full must not be taken.
      in_ctrl = 8'hC3; in_data = 32'hCCCC_CCCC;
      @(negedge clk);
      n_tests++; if (out_data !== 32'hAAAA_AAAA || out_ctrl !== 8'hA1 || in_ready !== 1'b0) begin
         n_fail++; $display("FAIL bb_hold got c=%h d=%h r=%0b want c=a1 d=aaaaaaaa r=0", out_ctrl, out_data, in_ready);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      n_tests++; if (out_valid !== 1'b1 || out_ctrl !== 8'hB2 || out_data !== 32'hBBBB_BBBB || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL bb_drain_b got v=%0b c=%h d=%h r=%0b want v=1 c=b2 d=bbbbbbbb r=1", out_valid, out_ctrl, out_data, in_ready);
      end
      @(negedge clk);
      n_tests++; if (out_valid !== 1'b0 || state !== ST_EMPTY) begin n_fail++; $display("FAIL bb_empty got v=%0b s=%b want v=0 s=00", out_valid, state); end
   endtask

   task automatic test_flush_full();
      out_ready = 1'b0;
      in_valid = 1'b1; in_ctrl = 8'h11; in_data = 32'h1111_1111;
      @(negedge clk);
      in_ctrl = 8'h22; in_data = 32'h2222_2222;
      @(negedge clk);
      in_valid = 1'b0;
      n_tests++; if (state !== ST_FULL) begin n_fail++; $display("FAIL fl_full got s=%b want s=11", state); end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      n_tests++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL fl_kill got v=%0b c=%h r=%0b want v=0 c=00 r=1", out_valid, out_ctrl, in_ready);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_no_emit_%0d got v=%0b c=%h want v=0", i, out_valid, out_ctrl); end
      end
   endtask

   task automatic test_flush_drop();
      in_valid = 1'b1; in_ctrl = 8'hFF; in_data = 32'hDEAD_BEEF; flush = 1'b1;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fd_ready got %0b want 1", in_ready); end
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      n_tests++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin n_fail++; $display("FAIL fd_drop got v=%0b c=%h want v=0 c=00", out_valid, out_ctrl); end
      @(negedge clk);
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fd_stay got v=%0b want 0", out_valid); end
   endtask

   task automatic test_perf();
      logic [NW-1:0] exp_stall;
      logic [NW-1:0] exp_bub1;
      logic [NW-1:0] exp_bub2;
`ifdef PIPE_STAGE_PERF_EN
      exp_stall = 4'hF; exp_bub1 = 4'h1; exp_bub2 = 4'h2;
`else
      exp_stall = 4'h0; exp_bub1 = 4'h0; exp_bub2 = 4'h0;
`endif
      #1 rst = 1'b1;
      #1;
      n_tests++; if (bubble_cnt !== 4'h0 || stall_cnt !== 4'h0) begin n_fail++; $display("FAIL perf_rst got %h/%h want 0/0", bubble_cnt, stall_cnt); end
      @(negedge clk);
      rst = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h42; in_data = 32'h4242_4242;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (20) @(negedge clk);
      n_tests++; if (stall_cnt !== exp_stall) begin n_fail++; $display("FAIL perf_stall_sat got %h want %h", stall_cnt, exp_stall); end
      n_tests++; if (bubble_cnt !== exp_bub1) begin n_fail++; $display("FAIL perf_bubble got %h want %h", bubble_cnt, exp_bub1); end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      n_tests++; if (stall_cnt !== exp_stall || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL perf_after_flush got stall=%h v=%0b want stall=%h v=0", stall_cnt, out_valid, exp_stall);
      end
      @(negedge clk);
      n_tests++; if (bubble_cnt !== exp_bub2) begin n_fail++; $display("FAIL perf_bubble_flush got %h want %h", bubble_cnt, exp_bub2); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_back_to_back();
      test_flush_full();
      test_flush_drop();
      test_perf();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
